// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-select add/subtract: one segment per stage, valid/ready with full backpressure.
// Optional CSA_PIPE_SATURATE_EN clamps the result on signed overflow at the output stage.

module csa_seg #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    logic [SW:0] cand0;
    logic [SW:0] cand1;

    assign cand0   = {1'b0, a} + {1'b0, b};
    assign cand1   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, 1'b1};
    assign {co, s} = ci ? cand1 : cand0;
endmodule

module csa_pipe_addsub #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSEG   = WIDTH / SEG_WIDTH;
    localparam int STAGES = NSEG - 1;

    // Operands ride along the whole pipe; s fills in one segment per stage.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    stage_t          acc;
    stage_t          st_d [NSEG];
    stage_t          st_q [NSEG];
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] adv;
    logic [STAGES:0] ld;

    always_comb begin
        acc.a  = a;
        acc.bp = op_sub ? ~b : b;
        acc.s  = '0;
        acc.c  = op_sub | cin;
    end

    // Advance ripples back from the consumer; a stage moves if the next slot frees up.
    always_comb begin
        adv         = '0;
        adv[STAGES] = vld_pipe[STAGES] & out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            adv[i] = vld_pipe[i] & (~vld_pipe[i+1] | adv[i+1]);
    end

    assign in_ready = ~vld_pipe[0] | adv[0];

    always_comb begin
        ld    = '0;
        ld[0] = in_valid & in_ready;
        for (int i = 1; i <= STAGES; i++)
            ld[i] = adv[i-1];
    end

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_stage
            stage_t                 src;
            logic [SEG_WIDTH-1:0]   seg_s;
            logic                   seg_c;

            if (k == 0) begin : g_first
                assign src = acc;
            end else begin : g_rest
                assign src = st_q[k-1];
            end

            csa_seg #(.SW(SEG_WIDTH)) u_seg (
                .a  (src.a[k*SEG_WIDTH +: SEG_WIDTH]),
                .b  (src.bp[k*SEG_WIDTH +: SEG_WIDTH]),
                .ci (src.c),
                .s  (seg_s),
                .co (seg_c)
            );

            always_comb begin
                st_d[k]                                = src;
                st_d[k].s[k*SEG_WIDTH +: SEG_WIDTH]    = seg_s;
                st_d[k].c                              = seg_c;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < NSEG; i++)
                st_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSEG; i++) begin
                vld_pipe[i] <= ld[i] | (vld_pipe[i] & ~adv[i]);
                if (ld[i])
                    st_q[i] <= st_d[i];
            end
        end
    end

    logic a_msb;
    assign a_msb     = st_q[STAGES].a[WIDTH-1];
    assign out_valid = vld_pipe[STAGES];
    assign cout      = st_q[STAGES].c;
    assign overflow  = (a_msb == st_q[STAGES].bp[WIDTH-1]) && (st_q[STAGES].s[WIDTH-1] != a_msb);

`ifdef CSA_PIPE_SATURATE_EN
    assign sum = !overflow ? st_q[STAGES].s :
                 a_msb     ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum = st_q[STAGES].s;
`endif
endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Bench for csa_pipe_addsub: arithmetic reference model, occupancy model for in_ready, directed vectors.
module tb_csa_pipe_addsub;
    localparam int NS = 4;
`ifdef CSA_PIPE_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, op_sub = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, cout, overflow;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2, cout2, ovf2;
    logic [15:0] a2 = '0, b2 = '0, sum2;

    always #5 clk = ~clk;

    csa_pipe_addsub #(.WIDTH(32), .SEG_WIDTH(8)) dut (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow));

    csa_pipe_addsub #(.WIDTH(16), .SEG_WIDTH(16)) dut1 (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(1'b0), .op_sub(1'b0), .out_valid(out_valid2),
        .out_ready(1'b1), .sum(sum2), .cout(cout2), .overflow(ovf2));

    typedef struct {
        logic [31:0] s; logic c; logic o; int cyc;
        logic lv; logic [31:0] ls; logic lc; logic lo;
    } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic ci; logic sb; logic [31:0] s; logic c; logic o; } vec_t;

    exp_t  q[$];
    int    q2[$];
    int    npass = 0, ntot = 0, tmo = 0, cyc = 0, occ = 0;
    logic  chk_lat = 1'b1, stl = 1'b0, pc, po;
    logic [31:0] ps;
    logic  lit_v = 1'b0, lit_c = 1'b0, lit_o = 1'b0;
    logic [31:0] lit_s = '0;
    vec_t  vt[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                                   input logic ms, input int mcyc);
        exp_t e; longint r; logic [32:0] u;
        if (ms) begin
            u = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
            r = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            u = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
            r = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        end
        e.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.s   = u[31:0];
        e.c   = u[32];
        if (SAT && e.o) e.s = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.cyc = mcyc;
        e.lv = 1'b0; e.ls = '0; e.lc = 1'b0; e.lo = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   t2;
        if (!rst_n) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_sum", {32'd0, sum}, 64'd0);
            chk("rst_cout", {63'd0, cout}, 64'd0);
            chk("rst_overflow", {63'd0, overflow}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_out_valid_n1", {63'd0, out_valid2}, 64'd0);
            q.delete(); q2.delete(); occ = 0; stl = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(occ == NS && !out_ready)});
            if (stl) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_sum", {32'd0, sum}, {32'd0, ps});
                chk("stall_cout", {63'd0, cout}, {63'd0, pc});
                chk("stall_ovf", {63'd0, overflow}, {63'd0, po});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", {63'd0, out_valid}, 64'd0);
                else begin
                    e = q.pop_front();
                    occ--;
                    chk("sum", {32'd0, sum}, {32'd0, e.s});
                    chk("cout", {63'd0, cout}, {63'd0, e.c});
                    chk("overflow", {63'd0, overflow}, {63'd0, e.o});
                    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(NS));
                    if (e.lv) begin
                        chk("lit_sum", {32'd0, sum}, {32'd0, e.ls});
                        chk("lit_cout", {63'd0, cout}, {63'd0, e.lc});
                        chk("lit_ovf", {63'd0, overflow}, {63'd0, e.lo});
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(a, b, cin, op_sub, cyc);
                e.lv = lit_v; e.ls = lit_s; e.lc = lit_c; e.lo = lit_o;
                q.push_back(e);
                occ++;
            end
            stl = out_valid && !out_ready;
            ps = sum; pc = cout; po = overflow;

            if (out_valid2) begin
                if (q2.size() == 0) chk("spurious_out_n1", {63'd0, out_valid2}, 64'd0);
                else begin
                    t2 = q2.pop_front();
                    chk("n1_latency", 64'(cyc - t2), 64'd1);
                    chk("n1_sum", {48'd0, sum2}, 64'h1235);
                    chk("n1_sum_model", {48'd0, sum2}, {48'd0, a2 + b2});
                    chk("n1_cout", {63'd0, cout2}, 64'd0);
                end
            end
            if (in_valid2 && in_ready2) q2.push_back(cyc);
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic isb,
                         input logic lv, input logic [31:0] ls, input logic lc, input logic lo);
        int n = 0;
        in_valid = 1'b1; a = ia; b = ib; cin = ic; op_sub = isb;
        lit_v = lv; lit_s = ls; lit_c = lc; lit_o = lo;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin tmo++; $display("FAIL accept_timeout: in_ready stuck at 0, required 1"); end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; lit_v = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin tmo++; $display("FAIL drain_timeout: %0d results pending, required 0", q.size()); end
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[5] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vt[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};
        vt[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 1'b1, vt[i].s, vt[i].c, vt[i].o);
            idle();
            drain();
        end

        for (int i = 0; i < 3; i++) issue(32'h1111_1111 * i, 32'h0F0F_0F0F, i[0], 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        drain();

        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue(32'h0100_0000 * i + i, 32'h0000_00FF * i, i[1], i[0], 1'b0, '0, 1'b0, 1'b0);
                idle();
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = (k % 3 == 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        for (int i = 0; i < 3; i++) issue(32'hA5A5_0000 + i, 32'h0000_1234, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        idle();
        drain();

        in_valid2 = 1'b1; a2 = 16'h1234; b2 = 16'h0001;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (q2.size() != 0) begin tmo++; $display("FAIL n1_timeout: %0d results pending, required 0", q2.size()); end

        $display("%0d/%0d checks passed", npass, ntot + tmo);
        $finish;
    end
endmodule
